// File: rtl/seven_seg_to_letter_rx.sv
// rtl/seven_seg_to_letter_rx.sv - segment pattern to letter decoder with output FIFO
module seven_seg_to_letter_rx #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_display,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_letra,
  output logic                     out_err,
  output logic [CW-1:0]            err_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [5:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [5:0]    dec;
  logic          push;
  logic          pop;
  logic [LW-1:0] level_nxt;

  // dec = {err, letra}; blank 0x00 is a legal letter, anything unlisted is an error
  always_comb begin
    dec = 6'h20;
    case (in_display)
      8'h00: dec = 6'h00;
      8'hF9: dec = 6'h01;
      8'h5B: dec = 6'h02;
      8'hC3: dec = 6'h03;
      8'h3B: dec = 6'h04;
      8'hD3: dec = 6'h05;
      8'hD1: dec = 6'h06;
      8'hFA: dec = 6'h07;
      8'h79: dec = 6'h08;
      8'h28: dec = 6'h09;
      8'h2B: dec = 6'h0A;
      8'h51: dec = 6'h0B;
      8'h43: dec = 6'h0C;
      8'h89: dec = 6'h0D;
      8'hE9: dec = 6'h0E;
      8'hEB: dec = 6'h0F;
      8'hF1: dec = 6'h10;
      8'hF8: dec = 6'h11;
      8'hC1: dec = 6'h12;
      8'hDA: dec = 6'h13;
      8'h53: dec = 6'h14;
      8'h6B: dec = 6'h15;
      8'h0B: dec = 6'h16;
      8'h62: dec = 6'h17;
      8'h38: dec = 6'h18;
      8'h7A: dec = 6'h19;
      8'hB3: dec = 6'h1A;
      default: dec = 6'h20;
    endcase
  end

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (level != '0);
  assign {out_err, out_letra} = out_valid ? mem[rd_ptr] : 6'h00;

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + LW'(1);
    else if (pop && !push)
      level_nxt = level - LW'(1);
  end

  // in_ready is registered from the next occupancy so it never combines with out_ready
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      in_ready  <= 1'b0;
      err_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      level    <= level_nxt;
      in_ready <= (level_nxt < FULL);
      if (push && dec[5] && (err_count != '1))
        err_count <= err_count + CW'(1);
    end
  end

endmodule

// File: tb/tb_seven_seg_to_letter_rx.sv
// tb/tb_seven_seg_to_letter_rx.sv - self-checking bench for seven_seg_to_letter_rx
module tb_seven_seg_to_letter_rx;

  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  localparam logic [7:0] TBL [27] = '{
    8'h00, 8'hF9, 8'h5B, 8'hC3, 8'h3B, 8'hD3, 8'hD1, 8'hFA, 8'h79,
    8'h28, 8'h2B, 8'h51, 8'h43, 8'h89, 8'hE9, 8'hEB, 8'hF1, 8'hF8,
    8'hC1, 8'hDA, 8'h53, 8'h6B, 8'h0B, 8'h62, 8'h38, 8'h7A, 8'hB3};

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_display;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_letra;
  logic          out_err;
  logic [CW-1:0] err_count;
  logic [2:0]    level;

  int n_chk  = 0;
  int n_fail = 0;

  seven_seg_to_letter_rx #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_display(in_display),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_letra(out_letra), .out_err(out_err),
    .err_count(err_count), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of {err, letra} values, decoded by searching the table
  int q[$];
  int m_cnt = 0;
  bit m_rdy = 0;
  bit started = 0;

  function automatic int decode(input logic [7:0] p);
    for (int i = 0; i < 27; i++)
      if (TBL[i] == p) return i;
    return 32;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_cnt   = 0;
      m_rdy   = 0;
      started = 1;
    end else if (started) begin
      int v;
      bit do_push;
      do_push = in_valid && m_rdy;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (do_push) begin
        v = decode(in_display);
        q.push_back(v);
        if (v >= 32 && m_cnt < CMAX) m_cnt++;
      end
      m_rdy = (q.size() < DEPTH);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, m_rdy);
      chk("level", level, q.size());
      chk("out_valid", out_valid, q.size() != 0);
      chk("err_count", err_count, m_cnt);
      if (q.size() != 0) begin
        chk("out_letra", out_letra, q[0] % 32);
        chk("out_err", out_err, q[0] >= 32);
      end
    end
  end

  task automatic step(input bit v, input logic [7:0] d, input bit r);
    in_valid   = v;
    in_display = d;
    out_ready  = r;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_display = 8'h00; out_ready = 0;
    @(negedge clk);
    step(0, 8'h00, 0);
    reset = 1'b0;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_letra", out_letra, 0);
    chk("rst out_err", out_err, 0);
    chk("rst level", level, 0);
    chk("rst err_count", err_count, 0);
    step(0, 8'h00, 0);
    chk("post-rst in_ready", in_ready, 1);

    // table sweep
    for (int i = 0; i < 27; i++) begin
      step(1, TBL[i], 1);
      chk("sweep letra", out_letra, i);
    end
    chk("sweep last letra", out_letra, 5'h1A);
    chk("sweep err_count", err_count, 0);
    step(0, 8'h00, 1);

    // unrecognised patterns
    step(1, 8'hFF, 0);
    step(1, 8'h01, 0);
    step(1, 8'hF9, 0);
    chk("err level", level, 3);
    chk("err count2", err_count, 2);
    chk("err head0 err", out_err, 1);
    chk("err head0 letra", out_letra, 0);
    step(0, 8'h00, 1);
    chk("err head1 err", out_err, 1);
    step(0, 8'h00, 1);
    chk("err head2 letra", out_letra, 5'h01);
    chk("err head2 err", out_err, 0);
    step(0, 8'h00, 1);
    chk("err empty", out_valid, 0);

    // fill with backpressure
    step(1, 8'h5B, 0);
    step(1, 8'hC3, 0);
    step(1, 8'h3B, 0);
    chk("fill3 in_ready", in_ready, 1);
    step(1, 8'hD3, 0);
    chk("full level", level, 4);
    chk("full in_ready", in_ready, 0);
    chk("full head", out_letra, 5'h02);
    step(1, 8'hF9, 0);
    chk("held level", level, 4);
    chk("held head", out_letra, 5'h02);

    // drain from full with in_valid held
    step(1, 8'hF9, 1);
    chk("drain1 level", level, 3);
    chk("drain1 head", out_letra, 5'h03);
    chk("drain1 in_ready", in_ready, 1);
    step(1, 8'hF9, 1);
    chk("drain2 level", level, 3);
    chk("drain2 head", out_letra, 5'h04);
    step(0, 8'h00, 1);
    chk("drain3 head", out_letra, 5'h05);
    step(0, 8'h00, 1);
    chk("drain4 head", out_letra, 5'h01);
    step(0, 8'h00, 1);
    chk("drain empty", out_valid, 0);

    // saturation
    for (int i = 0; i < 20; i++)
      step(1, (i % 2) ? 8'hFF : 8'h01, 1);
    chk("sat err_count", err_count, 15);
    step(0, 8'h00, 1);
    chk("sat hold", err_count, 15);

    // reset mid-stream
    step(1, 8'hF9, 0);
    step(1, 8'h5B, 0);
    step(1, 8'hC3, 0);
    chk("pre-rst level", level, 3);
    reset = 1'b1;
    step(0, 8'h00, 0);
    chk("mid-rst out_valid", out_valid, 0);
    chk("mid-rst level", level, 0);
    chk("mid-rst err_count", err_count, 0);
    chk("mid-rst in_ready", in_ready, 0);
    reset = 1'b0;
    step(0, 8'h00, 0);
    chk("after-rst in_ready", in_ready, 1);
    step(0, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
